hamming_secded_decoder: RTL
===========================

# hamming_secded_decoder

Parametrised Hamming SECDED (single-error-correct, double-error-detect) decoder for arbitrary data widths, successor to the fixed 7-bit single-error corrector. Accepts an extended Hamming codeword over a valid/ready stream, corrects any single-bit error, and flags double errors. Results leave through a two-stage registered pipeline with backpressure. Sits on the receive side of the Hamming system, between channel/storage and the data consumer.

## Interface

- DATA_W, 4, payload width in bits; legal range 4..120.
- P, derived (localparam), number of Hamming parity bits; smallest P with 2^P >= DATA_W+P+1 (DATA_W=4 gives P=3).
- CW, derived (localparam), codeword width = DATA_W+P+1.
- CNT_W, 16, width of each error counter.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword present on code_in.
- in_ready  out  1  decoder accepts code_in this cycle.
- code_in  in  CW  codeword: bit 0 = overall parity; bits 1..CW-1 = Hamming positions 1..CW-1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result this cycle.
- data_out  out  DATA_W  corrected (or raw, on double error) payload.
- err_single  out  1  single-bit error found and corrected.
- err_double  out  1  uncorrectable error detected.
- err_pos  out  P  corrected Hamming position; 0 when none or when overall-parity bit corrected.
- clr_cnt  in  1  synchronous clear of both counters.
- sec_count  out  CNT_W  saturating count of single-error results.
- ded_count  out  CNT_W  saturating count of double-error results.

## Operation

- Layout: parity bits at power-of-two positions 1,2,4,...; data bits fill remaining positions 3,5,6,7,9,... in ascending order, data bit 0 at lowest position.
- Syndrome s = XOR of position indices of all set bits in positions 1..CW-1; overall parity p = XOR of all CW bits.
- Classification:
  - s=0, p=0: clean; data extracted unchanged; no flags.
  - p=1, s=0: overall-parity bit in error; err_single=1, err_pos=0, data unchanged.
  - p=1, 1<=s<=CW-1: flip position s; err_single=1, err_pos=s.
  - p=1, s>CW-1: err_double=1, raw data, err_pos=0.
  - p=0, s!=0: err_double=1, raw data, err_pos=0.
- err_single and err_double never both 1.
- Stage 1 registers codeword, s, p; stage 2 registers data_out, flags, err_pos.
- Counters increment when stage 2 loads a valid result with the matching flag; saturate at all-ones; clr_cnt has priority over increment in the same cycle.

## Timing

- Advance condition adv = !out_valid || out_ready; in_ready = adv (combinational from out_valid/out_ready).
- Both stages move together on adv; stage-1 valid loads in_valid&&in_ready; out_valid loads stage-1 valid.
- Latency: code accepted in cycle N appears on outputs at cycle N+2 with no stall.
- Throughput: one word per cycle while out_ready=1; internal bubbles are not collapsed.
- Stall: while out_valid=1 and out_ready=0, all outputs and pipeline contents hold stable.
- Reset: all outputs 0, both stage valids 0, counters 0; reset mid-stream discards in-flight words without counting them.

## Configuration

- HAMMING_ERR_CNT_EN: defined, counters and clr_cnt logic are built as described. Undefined, counter registers are omitted, sec_count and ded_count are tied to 0, and clr_cnt is ignored. Decode behaviour and timing are identical either way.

## Test plan

- DATA_W=4, code_in=8'hAA, out_ready=1 -> two cycles later data_out=4'hB, err_single=0, err_double=0, err_pos=0.
- code_in=8'h8A (position 5 flipped) -> data_out=4'hB, err_single=1, err_pos=5, sec_count increments 0->1.
- code_in=8'hAB (overall-parity bit flipped) -> data_out=4'hB, err_single=1, err_pos=0.
- code_in=8'h82 (positions 3 and 5 flipped) -> data_out=4'h8 raw, err_double=1, err_pos=0, ded_count=1.
- Back-to-back stream of 10 words with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs hold, no word lost or duplicated, order preserved.
- Counters: force sec_count to saturation with CNT_W=2 (4 single-error words) -> holds 3; assert clr_cnt with a concurrent single-error result -> 0. Assert rst mid-stream -> out_valid=0 next edge, counters 0.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// Parametrised extended-Hamming SECDED decoder with a two-stage valid/ready pipeline.
// Define HAMMING_ERR_CNT_EN to build the saturating single/double error counters.
module hamming_secded_decoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int P      = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CW     = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [P-1:0]      err_pos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  // Hamming position of data bit j: the j-th non-power-of-two position.
  function automatic int dpos(input int j);
    int n, r;
    n = 0;
    r = 0;
    for (int i = 1; i < 256; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == j) r = i;
        n++;
      end
    end
    return r;
  endfunction

  logic              adv;
  logic [1:0]        vld_q, vld_d;
  logic [CW-1:0]     s1_code_q;
  logic [P-1:0]      s1_syn_q, syn_d;
  logic              s1_par_q, par_d;
  logic [CW-1:0]     fix;
  logic [DATA_W-1:0] data_d, data_q;
  logic              es_d, ed_d, es_q, ed_q;
  logic [P-1:0]      pos_d, pos_q;

  assign adv      = !vld_q[1] || out_ready;
  assign in_ready = adv;
  assign vld_d    = {vld_q[0], in_valid};

  always_comb begin
    syn_d = '0;
    for (int i = 1; i < CW; i++) begin
      if (code_in[i]) syn_d = syn_d ^ P'(i);
    end
    par_d = ^code_in;
  end

  // Flags are qualified by stage-1 valid so bubbles never raise them or bump counters.
  always_comb begin
    es_d  = 1'b0;
    ed_d  = 1'b0;
    pos_d = '0;
    fix   = s1_code_q;
    if (vld_q[0]) begin
      if (s1_par_q) begin
        if (int'(s1_syn_q) < CW) begin
          es_d  = 1'b1;
          pos_d = s1_syn_q;
          fix   = s1_code_q ^ (CW'(1) << s1_syn_q);
        end else begin
          ed_d = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        ed_d = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    assign data_d[j] = fix[dpos(j)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_code_q <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
      data_q    <= '0;
      es_q      <= 1'b0;
      ed_q      <= 1'b0;
      pos_q     <= '0;
    end else if (adv) begin
      vld_q     <= vld_d;
      s1_code_q <= code_in;
      s1_syn_q  <= syn_d;
      s1_par_q  <= par_d;
      data_q    <= data_d;
      es_q      <= es_d;
      ed_q      <= ed_d;
      pos_q     <= pos_d;
    end
  end

  assign out_valid  = vld_q[1];
  assign data_out   = data_q;
  assign err_single = es_q;
  assign err_double = ed_q;
  assign err_pos    = pos_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;

  always_comb begin
    sec_d = sec_q;
    ded_d = ded_q;
    if (clr_cnt) begin
      sec_d = '0;
      ded_d = '0;
    end else if (adv) begin
      if (es_d && (sec_q != '1)) sec_d = sec_q + 1'b1;
      if (ed_d && (ded_q != '1)) ded_d = ded_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      sec_q <= sec_d;
      ded_q <= ded_d;
    end
  end

  assign sec_count = sec_q;
  assign ded_count = ded_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sec_count  = '0;
  assign ded_count  = '0;
`endif

endmodule
